ifetch_unit: RTL and testbench

- Fetch-side consumer of the program counter.
- Issues PC values as instruction-memory requests through a valid/ready handshake and tracks in-order responses.
- Buffers returned instructions with their PCs in a small queue feeding decode.
- Drives the PC's advance enable, so the PC steps only when a fetch request is accepted or a redirect occurs.
- Discards in-flight fetches on a branch/JALR redirect (flush).

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_unit_sync_fifo.sv | 61 ++++++
 rtl/ifetch_unit.sv | 133 +++++++++++++
 tb/tb_ifetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifetch_pkg;

  localparam int PKG_XLEN = 32;

  // Architectural constants used by the fetch path and its environment.
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;

  // Counter width for outstanding/drop/occupancy counts; must hold QDEPTH.
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO with flush and occupancy count.
// Reset is synchronous, active-low. A push on a full FIFO is accepted only
// together with a pop; flush empties the FIFO and wins over a same-cycle push.
module sync_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output cnt_t             count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  cnt_t             cnt;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointer advance with explicit wrap so non-power-of-two depths also work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (cnt == '0);
  assign full      = (cnt == cnt_t'(DEPTH));
  assign do_push   = push & (~full | pop);
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];
  assign count     = cnt;

  // Storage array: written on push, no reset needed on the data itself.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; reset and flush both return to empty.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      cnt <= cnt + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: issues the current PC to imem, tracks in-order
// responses, buffers {pc, instr} for decode and drops stale responses after a
// redirect. Optional macro IFETCH_BYPASS_EN presents a response on the decode
// port in the same cycle when the queue is empty and nothing is being dropped.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int MAX_OUT = 2,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_en_o,
  input  logic            flush_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pcplus4_o
);

  cnt_t              out_cnt;
  cnt_t              out_cnt_next;
  cnt_t              drop_cnt;
  cnt_t              drop_cnt_next;
  cnt_t              q_count;
  cnt_t              pc_count;
  logic [XLEN-1:0]   pc_head;
  logic [2*XLEN-1:0] q_head;
  logic              req_room;
  logic              handshake;
  logic              rsp_keep;
  logic              bypass;
  logic              q_push;
  logic              q_pop;
  logic              q_nonempty;

  // Every issued request reserves a queue slot, so responses never overflow.
  assign req_room = (int'(out_cnt) < MAX_OUT) &&
                    (int'(out_cnt) + int'(q_count) < QDEPTH);

  assign imem_req_valid_o = rst & ~flush_i & req_room;
  assign imem_req_addr_o  = pc_i;
  assign handshake        = imem_req_valid_o & imem_req_ready_i;
  assign pc_en_o          = handshake | (rst & flush_i);

  // A response is kept only when nothing is pending discard and no redirect
  // is happening right now (a flush-cycle response is stale by definition).
  assign rsp_keep   = rst & imem_rsp_valid_i & (drop_cnt == '0) & ~flush_i;
  assign q_nonempty = (q_count != '0);

`ifdef IFETCH_BYPASS_EN
  assign bypass = rsp_keep & ~q_nonempty;
`else
  assign bypass = 1'b0;
`endif

  assign q_push = rsp_keep & ~(bypass & id_ready_i);
  assign q_pop  = rst & q_nonempty & id_ready_i;

  assign id_valid_o   = rst & (q_nonempty | bypass);
  assign id_pc_o      = bypass ? pc_head         : q_head[2*XLEN-1:XLEN];
  assign id_instr_o   = bypass ? imem_rsp_data_i : q_head[XLEN-1:0];
  assign id_pcplus4_o = id_pc_o + XLEN'(4);

  // PC side-FIFO: address of each outstanding request, popped per response.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (handshake),
    .push_data (pc_i),
    .pop       (rst & imem_rsp_valid_i),
    .flush     (1'b0),
    .head_data (pc_head),
    .count     (pc_count)
  );

  // Fetch queue feeding decode.
  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(QDEPTH)) u_fetch_q (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({pc_head, imem_rsp_data_i}),
    .pop       (q_pop),
    .flush     (flush_i),
    .head_data (q_head),
    .count     (q_count)
  );

  // Outstanding and drop counter updates; a flush re-arms the drop count.
  always_comb begin
    out_cnt_next  = out_cnt;
    drop_cnt_next = drop_cnt;
    if (handshake && !imem_rsp_valid_i) begin
      out_cnt_next = out_cnt + cnt_t'(1);
    end else if (!handshake && imem_rsp_valid_i && out_cnt != '0) begin
      out_cnt_next = out_cnt - cnt_t'(1);
    end
    if (flush_i) begin
      drop_cnt_next = (imem_rsp_valid_i && out_cnt != '0) ? out_cnt - cnt_t'(1) : out_cnt;
    end else if (imem_rsp_valid_i && drop_cnt != '0) begin
      drop_cnt_next = drop_cnt - cnt_t'(1);
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      out_cnt  <= out_cnt_next;
      drop_cnt <= drop_cnt_next;
    end
  end

  // Bookkeeping sanity: no response without an outstanding request, and the
  // PC side-FIFO occupancy always matches the outstanding count.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(imem_rsp_valid_i && out_cnt == '0));
      assert (pc_count == out_cnt);
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed table of per-cycle vectors
// followed by randomized traffic, both checked against an epoch-based model.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int QD = 4;
  localparam int MO = 2;
  localparam logic [31:0] TGT_A = 32'hBFC00100;
  localparam logic [31:0] TGT_B = 32'hBFC00200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_en;
  logic        flush = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pcplus4;

  always #5 clk = ~clk;

  ifetch_unit #(.QDEPTH(QD), .MAX_OUT(MO), .XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc),
    .pc_en_o          (pc_en),
    .flush_i          (flush),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .id_valid_o       (id_valid),
    .id_ready_i       (id_ready),
    .id_instr_o       (id_instr),
    .id_pc_o          (id_pc),
    .id_pcplus4_o     (id_pcplus4)
  );

  // Reference model: accepted requests carry the redirect epoch they were
  // issued in; a response survives only if no redirect happened since.
  typedef struct { logic [31:0] pc; int ep; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct {
    logic r, fl, rdy, rsp, idr;
    logic [31:0] tgt;
    logic e_rv, e_pe, e_idv;
    logic [31:0] e_pc;
  } vec_t;

  req_t        req_q[$];
  ent_t        exp_q[$];
  int          epoch = 0;
  logic [31:0] pc_m = RESET_VECTOR;
  int          total = 0;
  int          bad = 0;
  vec_t        vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic r, fl, rdy, rsp, idr, input logic [31:0] tgt,
                              input logic e_rv, e_pe, e_idv, input logic [31:0] e_pc);
    vec_t v;
    v.r = r; v.fl = fl; v.rdy = rdy; v.rsp = rsp; v.idr = idr; v.tgt = tgt;
    v.e_rv = e_rv; v.e_pe = e_pe; v.e_idv = e_idv; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic do_cycle(input logic r, fl, rdy, rsp, idr, input logic [31:0] tgt,
                          input bit tab, input vec_t v);
    logic rsp_go, kept, byp, m_rv, m_pe, m_idv, consumed;
    ent_t head;
    req_t rq;
    rst = r; flush = fl; req_ready = rdy; id_ready = idr; pc = pc_m;
    rsp_go = rsp && r && (req_q.size() > 0);
    rsp_valid = rsp_go;
    rsp_data = rsp_go ? mem_word(req_q[0].pc) : 32'h0;
    m_rv = r && !fl && (req_q.size() < MO) && (req_q.size() + exp_q.size() < QD);
    m_pe = (m_rv && rdy) || (r && fl);
    kept = rsp_go && (req_q[0].ep == epoch) && !fl;
    byp = 1'b0;
`ifdef IFETCH_BYPASS_EN
    byp = kept && (exp_q.size() == 0);
`endif
    m_idv = r && ((exp_q.size() > 0) || byp);
    head.pc = '0; head.instr = '0;
    if (exp_q.size() > 0) head = exp_q[0];
    else if (byp) begin head.pc = req_q[0].pc; head.instr = mem_word(req_q[0].pc); end

    @(negedge clk);
    check("req_valid", req_valid, m_rv);
    check("pc_en", pc_en, m_pe);
    check("req_addr", req_addr, pc_m);
    check("id_valid", id_valid, m_idv);
    if (m_idv) begin
      check("id_pc", id_pc, head.pc);
      check("id_instr", id_instr, head.instr);
      check("id_pcplus4", id_pcplus4, head.pc + 32'd4);
    end
    if (tab) begin
      check("tab_req_valid", req_valid, v.e_rv);
      check("tab_pc_en", pc_en, v.e_pe);
      check("tab_id_valid", id_valid, v.e_idv);
      if (v.e_idv) check("tab_id_pc", id_pc, v.e_pc);
    end

    @(posedge clk);
    if (!r) begin
      req_q.delete(); exp_q.delete(); pc_m = RESET_VECTOR;
    end else begin
      rq.pc = '0; rq.ep = 0;
      if (rsp_go) rq = req_q.pop_front();
      if (fl) begin
        epoch++; exp_q.delete(); pc_m = tgt;
      end else begin
        consumed = byp && idr;
        if (exp_q.size() > 0 && idr) void'(exp_q.pop_front());
        if (kept && !consumed) exp_q.push_back('{rq.pc, mem_word(rq.pc)});
        if (m_rv && rdy) begin
          req_q.push_back('{pc_m, epoch});
          pc_m = pc_m + 32'd4;
        end
      end
    end
    #1;
  endtask

  initial begin
    vec_t nv;
    nv = mk(0,0,0,0,0,'0,0,0,0,'0);
    // r, fl, rdy, rsp, idr, tgt | req_valid, pc_en, id_valid, id_pc
    // reset held 3 cycles, then streaming
    vecs.push_back(mk(0,0,1,0,1,'0, 0,0,0,'0));
    vecs.push_back(mk(0,0,1,0,1,'0, 0,0,0,'0));
    vecs.push_back(mk(0,0,1,0,1,'0, 0,0,0,'0));
    vecs.push_back(mk(1,0,1,0,1,'0, 1,1,0,'0));
    vecs.push_back(mk(1,0,1,1,1,'0, 1,1,0,'0));
    vecs.push_back(mk(1,0,1,1,1,'0, 1,1,1,RESET_VECTOR));
    vecs.push_back(mk(1,0,1,1,1,'0, 1,1,1,RESET_VECTOR + 32'h4));
    // decode back-pressure: queue fills to 4, issue stalls
    vecs.push_back(mk(1,0,1,1,0,'0, 1,1,1,RESET_VECTOR + 32'h8));
    vecs.push_back(mk(1,0,1,1,0,'0, 1,1,1,RESET_VECTOR + 32'h8));
    vecs.push_back(mk(1,0,1,1,0,'0, 0,0,1,RESET_VECTOR + 32'h8));
    vecs.push_back(mk(1,0,1,0,0,'0, 0,0,1,RESET_VECTOR + 32'h8));
    vecs.push_back(mk(1,0,1,0,0,'0, 0,0,1,RESET_VECTOR + 32'h8));
    vecs.push_back(mk(1,0,1,0,1,'0, 0,0,1,RESET_VECTOR + 32'h8));
    vecs.push_back(mk(1,0,1,0,1,'0, 1,1,1,RESET_VECTOR + 32'hC));
    vecs.push_back(mk(1,0,1,0,1,'0, 1,1,1,RESET_VECTOR + 32'h10));
    vecs.push_back(mk(1,0,1,0,1,'0, 0,0,1,RESET_VECTOR + 32'h14));
    // flush with 2 outstanding; both responses dropped
    vecs.push_back(mk(1,1,1,0,1,TGT_A, 0,1,0,'0));
    vecs.push_back(mk(1,0,1,1,1,'0, 0,0,0,'0));
    vecs.push_back(mk(1,0,1,1,1,'0, 1,1,0,'0));
    vecs.push_back(mk(1,0,1,1,1,'0, 1,1,0,'0));
    vecs.push_back(mk(1,0,1,0,1,'0, 1,1,1,TGT_A));
    // flush coinciding with a response: one more drop
    vecs.push_back(mk(1,1,1,1,1,TGT_B, 0,1,0,'0));
    vecs.push_back(mk(1,0,1,1,1,'0, 1,1,0,'0));
    vecs.push_back(mk(1,0,1,1,1,'0, 1,1,0,'0));
    vecs.push_back(mk(1,0,1,0,1,'0, 1,1,1,TGT_B));
    // imem stall for 5 cycles
    vecs.push_back(mk(1,0,0,1,0,'0, 0,0,0,'0));
    vecs.push_back(mk(1,0,0,1,0,'0, 1,0,1,TGT_B + 32'h4));
    vecs.push_back(mk(1,0,0,0,0,'0, 1,0,1,TGT_B + 32'h4));
    vecs.push_back(mk(1,0,0,0,0,'0, 1,0,1,TGT_B + 32'h4));
    vecs.push_back(mk(1,0,0,0,0,'0, 1,0,1,TGT_B + 32'h4));
    vecs.push_back(mk(1,0,1,0,1,'0, 1,1,1,TGT_B + 32'h4));
    vecs.push_back(mk(1,0,1,1,1,'0, 1,1,1,TGT_B + 32'h8));
    vecs.push_back(mk(1,0,0,1,1,'0, 1,0,1,TGT_B + 32'hC));
    vecs.push_back(mk(1,0,0,0,1,'0, 1,0,1,TGT_B + 32'h10));
    vecs.push_back(mk(1,0,0,0,1,'0, 1,0,0,'0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      bit use_tab;
`ifdef IFETCH_BYPASS_EN
      use_tab = 1'b0;
`else
      use_tab = 1'b1;
`endif
      do_cycle(vecs[i].r, vecs[i].fl, vecs[i].rdy, vecs[i].rsp, vecs[i].idr,
               vecs[i].tgt, use_tab, vecs[i]);
      $display("row %0d: rst=%0b flush=%0b rdy=%0b rsp=%0b idr=%0b id_valid=%0b id_pc=%h",
               i, vecs[i].r, vecs[i].fl, vecs[i].rdy, vecs[i].rsp, vecs[i].idr, id_valid, id_pc);
    end

    // Randomized traffic including occasional mid-operation reset.
    for (int i = 0; i < 1200; i++) begin
      logic r, fl;
      logic [31:0] t;
      r = (i < 2) ? 1'b0 : ($urandom_range(0, 79) != 0);
      fl = ($urandom_range(0, 11) == 0);
      t = $urandom();
      t[1:0] = 2'b00;
      do_cycle(r, fl, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) != 0, t, 1'b0, nv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
